spi_access_irq: RTL and testbench

Multi-channel successor to the single-channel SPI access request generator. Each of NCH channels turns an arm level plus a go rising edge, and optionally a periodic timeout while armed, into a sticky request flag that stays high until acknowledged or disarmed. The block sits between the slow-control register interface (arm/go/ack/period) and the SPI master sequencer, which consumes `irq` and `pending_id`.

---
 rtl/spi_access_pkg.sv | 22 ++
 rtl/spi_access_chan.sv | 101 ++++++++++
 rtl/spi_access_irq.sv | 65 ++++++
 tb/tb_spi_access_irq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_access_pkg.sv
// Shared constants and helpers for the SPI access request generator.
// Contents:
//   SPI_CNT_W_DEF   default timer/period width in bits
//   SPI_PERIOD_1MS  period value giving 1 ms at a 100 MHz clk
//   lowest_set_idx  priority encoder used for pending_id (lowest index wins)
package spi_access_pkg;

   localparam int unsigned SPI_CNT_W_DEF  = 17;
   localparam int unsigned SPI_PERIOD_1MS = 100000;

   // Returns the index of the lowest set bit; 0 when no bit is set.
   function automatic logic [3:0] lowest_set_idx(input logic [15:0] vec);
      logic [3:0] idx;
      idx = '0;
      // Scanning downwards lets the lowest set bit overwrite higher ones.
      for (int unsigned i = 16; i > 0; i--) begin
         if (vec[i-1]) idx = 4'(i - 1);
      end
      return idx;
   endfunction

endpackage

// File: rtl/spi_access_chan.sv
// One request channel: arm/go edge detection, optional periodic timer,
// sticky request flag and sticky overflow flag.
// Optional feature macro: SPI_ACCESS_PERIODIC_EN (builds cnt/per_lat timer).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   arm         enable level; arm=0 clears everything
//   go          trigger, rising edge only
//   ack         single-cycle clear of the request
//   period      timeout in clk cycles, latched on arm rise (ignored without timer)
//   int_out     sticky request flag (registered)
//   int_nxt     next-state of int_out, used by the top for an aligned irq
//   overflow    sticky flag, set when an event arrives while int_out is set
module spi_access_chan #(
   parameter int unsigned CNT_W = spi_access_pkg::SPI_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arm,
   input  logic             go,
   input  logic             ack,
   input  logic [CNT_W-1:0] period,
   output logic             int_out,
   output logic             int_nxt,
   output logic             overflow
);

   logic arm_d1;
   logic go_d1;
   logic go_rise;
   logic tick;
   logic evt;
   logic ov_nxt;

`ifdef SPI_ACCESS_PERIODIC_EN
   logic             arm_rise;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] per_lat;

   always_comb begin
      arm_rise = arm & ~arm_d1;
      // per_lat of zero never matches, so the counter just wraps silently.
      tick     = arm & ~arm_rise & (per_lat != '0) & (cnt == per_lat - 1'b1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         per_lat <= '0;
      end else if (arm_rise) begin
         cnt     <= '0;
         per_lat <= period;
      end else if (arm) begin
         if (tick) cnt <= '0;
         else      cnt <= cnt + 1'b1;
      end else begin
         cnt <= '0;
      end
   end
`else
   logic unused_period;

   assign unused_period = ^period;
   assign tick          = 1'b0;
`endif

   always_comb begin
      go_rise = go & ~go_d1;
      evt     = (go_rise & arm) | tick;
   end

   // An event in the same cycle as ack wins for int_out, while ack still
   // clears overflow: the ack consumes the old request, the new one stays.
   always_comb begin
      int_nxt = int_out;
      ov_nxt  = overflow;
      if (!arm) begin
         int_nxt = 1'b0;
         ov_nxt  = 1'b0;
      end else begin
         if (evt)      int_nxt = 1'b1;
         else if (ack) int_nxt = 1'b0;
         if (ack)                 ov_nxt = 1'b0;
         else if (evt && int_out) ov_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         arm_d1   <= 1'b0;
         go_d1    <= 1'b0;
         int_out  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         arm_d1   <= arm;
         go_d1    <= go;
         int_out  <= int_nxt;
         overflow <= ov_nxt;
      end
   end

endmodule

// File: rtl/spi_access_irq.sv
// Multi-channel SPI access request generator. NCH independent channels
// produce sticky requests; the top combines them into a registered irq and
// a lowest-index-first pending_id for the SPI master sequencer.
// Optional feature macro: SPI_ACCESS_PERIODIC_EN (per-channel periodic timer).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   arm[NCH]     per-channel enable level
//   go[NCH]      per-channel trigger (rising edge)
//   ack[NCH]     per-channel clear pulse
//   period       shared timeout in clk cycles, latched per channel on arm rise
//   int_out[NCH] per-channel sticky request
//   overflow[NCH] per-channel sticky lost-event flag
//   irq          registered OR of int_out, cycle-aligned with int_out
//   pending_id   index of the lowest set int_out, 0 when none
module spi_access_irq
   import spi_access_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CNT_W = SPI_CNT_W_DEF,
   localparam int unsigned PID_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   arm,
   input  logic [NCH-1:0]   go,
   input  logic [NCH-1:0]   ack,
   input  logic [CNT_W-1:0] period,
   output logic [NCH-1:0]   int_out,
   output logic [NCH-1:0]   overflow,
   output logic             irq,
   output logic [PID_W-1:0] pending_id
);

   logic [NCH-1:0] int_nxt;
   logic [15:0]    int_vec;

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      spi_access_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .arm      (arm[g]),
         .go       (go[g]),
         .ack      (ack[g]),
         .period   (period),
         .int_out  (int_out[g]),
         .int_nxt  (int_nxt[g]),
         .overflow (overflow[g])
      );
   end

   // Built from next-state so irq rises and falls on the same edge as int_out.
   always_ff @(posedge clk) begin
      if (!rst_n) irq <= 1'b0;
      else        irq <= |int_nxt;
   end

   always_comb begin
      int_vec            = '0;
      int_vec[NCH-1:0]   = int_out;
      pending_id         = PID_W'(lowest_set_idx(int_vec));
   end

endmodule

// File: tb/tb_spi_access_irq.sv
// Self-checking bench for spi_access_irq (NCH=4, CNT_W=17).
// Table of go/ack/arm vectors runs in both builds (period=0 so no timer
// ticks); timer scenarios are exercised when SPI_ACCESS_PERIODIC_EN is set.
module tb_spi_access_irq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  arm, go, ack;
   logic [16:0] period;
   logic [3:0]  int_out, overflow;
   logic        irq;
   logic [1:0]  pending_id;

   int checks = 0;
   int errors = 0;

   spi_access_irq #(
      .NCH   (4),
      .CNT_W (17)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arm        (arm),
      .go         (go),
      .ack        (ack),
      .period     (period),
      .int_out    (int_out),
      .overflow   (overflow),
      .irq        (irq),
      .pending_id (pending_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] arm;
      logic [3:0] go;
      logic [3:0] ack;
      logic [3:0] exp_int;
      logic [3:0] exp_ov;
      logic       exp_irq;
      logic [1:0] exp_pid;
   } vec_t;

   vec_t tbl[25];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " int_out"},    int'(int_out),    0);
      chk({tag, " overflow"},   int'(overflow),   0);
      chk({tag, " irq"},        int'(irq),        0);
      chk({tag, " pending_id"}, int'(pending_id), 0);
   endtask

   initial begin
      logic seen;

      //            arm      go       ack      int      ov       irq   pid
      tbl[0]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[1]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1};
      tbl[2]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1};
      tbl[3]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[4]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[5]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[6]  = '{4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 1'b1, 2'd1};
      tbl[7]  = '{4'b1010, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 1'b1, 2'd1};
      tbl[8]  = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b1, 2'd3};
      tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[10] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[11] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[12] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[13] = '{4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 1'b1, 2'd3};
      tbl[14] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b1, 2'd3};
      tbl[15] = '{4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b1, 2'd3};
      tbl[16] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[17] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[18] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 2'd3};
      tbl[19] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b1, 2'd3};
      tbl[20] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 2'd3};
      tbl[21] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[22] = '{4'b0101, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 1'b1, 2'd0};
      tbl[23] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2};
      tbl[24] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};

      // Reset state
      rst_n  = 1'b0;
      arm    = '0;
      go     = '0;
      ack    = '0;
      period = '0;
      step();
      step();
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Directed vector table: inputs sampled at an edge, outputs checked after it
      for (int i = 0; i < 25; i++) begin
         arm = tbl[i].arm;
         go  = tbl[i].go;
         ack = tbl[i].ack;
         step();
         chk($sformatf("vec%0d int_out", i),    int'(int_out),    int'(tbl[i].exp_int));
         chk($sformatf("vec%0d overflow", i),   int'(overflow),   int'(tbl[i].exp_ov));
         chk($sformatf("vec%0d irq", i),        int'(irq),        int'(tbl[i].exp_irq));
         chk($sformatf("vec%0d pending_id", i), int'(pending_id), int'(tbl[i].exp_pid));
      end

`ifdef SPI_ACCESS_PERIODIC_EN
      // Periodic: P=10, arm rise at E0, ack at E12 -> set at E10, E20
      arm = '0; go = '0; ack = '0;
      step();
      period = 17'd10;
      arm    = 4'b0001;
      step();
      for (int k = 1; k <= 25; k++) begin
         ack = (k == 12) ? 4'b0001 : 4'b0000;
         step();
         chk($sformatf("per10 E%0d int0", k), int'(int_out[0]),
             ((k >= 10 && k < 12) || k >= 20) ? 1 : 0);
      end
      ack = '0;
      chk("per10 irq", int'(irq), 1);

      // Period 0: never ticks
      arm = '0;
      step();
      period = '0;
      arm    = 4'b0001;
      seen   = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         step();
         seen = seen | int_out[0];
      end
      chk("per0 no set", int'(seen), 0);

      // Overflow: P=4 on ch2, set E4, overflow E8, ack E9, ack+tick at E12
      arm = '0;
      step();
      period = 17'd4;
      arm    = 4'b0100;
      step();
      for (int k = 1; k <= 12; k++) begin
         ack = (k == 9 || k == 12) ? 4'b0100 : 4'b0000;
         step();
         chk($sformatf("ovf E%0d int2", k), int'(int_out[2]),
             ((k >= 4 && k <= 8) || k == 12) ? 1 : 0);
         chk($sformatf("ovf E%0d ov2", k), int'(overflow[2]), (k == 8) ? 1 : 0);
      end
      ack = '0;
`endif

      // Reset mid-operation
      arm = '0; go = '0; ack = '0;
      step();
      period = 17'd100;
      arm    = 4'b0011;
      go     = 4'b0010;
      step();
      go = '0;
      for (int k = 1; k < 50; k++) step();
      chk("pre-reset int_out", int'(int_out), 4'b0010);
      rst_n = 1'b0;
      step();
      chk_all_zero("mid-reset");
      rst_n = 1'b1;
      step();   // R0: arm still high -> arm rise
`ifdef SPI_ACCESS_PERIODIC_EN
      for (int k = 1; k <= 100; k++) begin
         step();
         if (k == 99)  chk("post-reset R99 int0",  int'(int_out[0]), 0);
         if (k == 100) chk("post-reset R100 int0", int'(int_out[0]), 1);
      end
`else
      chk("post-reset R0 int_out", int'(int_out), 0);

      // No timer: armed channels never set without a go rise
      arm = '0;
      step();
      period = 17'd5;
      arm    = 4'b1111;
      seen   = 1'b0;
      for (int k = 0; k < 200; k++) begin
         step();
         seen = seen | (|int_out);
      end
      chk("no-timer no set", int'(seen), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
